// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: per channel a 2-FF synchroniser, debouncer,
// press/release edge pulses, long-press detection and optional auto-repeat.
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] sync_p0;
  logic [N_CH-1:0] sync_p1;

  // Polarity is normalised before the synchroniser so that reset (0) always means released.
  assign raw = pb_in ^ {N_CH{ACTIVE_LOW}};

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DB_W-1:0]   db_cnt;
    logic              db_q;
    logic              press_q;
    logic              release_q;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;
    logic              long_q;
    logic              repeat_q;
    logic              accept;

    assign accept = (sync_p1[i] != db_q) && (db_cnt == DB_LAST);

    // Stage p2: debounce and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt    <= '0;
        db_q      <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sync_p1[i] == db_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt    <= '0;
          db_q      <= sync_p1[i];
          press_q   <= sync_p1[i];
          release_q <= ~sync_p1[i];
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // Hold-time FSM runs in parallel with the debouncer, keyed off the same accept edge,
    // so long_pulse lands exactly LONG_CYCLES after press_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        hold_cnt <= '0;
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
        if (accept && db_q) begin
          // Release takes priority over a coincident long/repeat terminal count.
          state    <= IDLE;
          hold_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept) begin
                state    <= HELD;
                hold_cnt <= '0;
              end
            end
            HELD: begin
              if (hold_cnt == LONG_LAST) begin
                long_q   <= 1'b1;
                hold_cnt <= '0;
                state    <= REPEAT;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
            REPEAT: begin
              if (REPEAT_EN) begin
                if (hold_cnt == REP_LAST) begin
                  repeat_q <= 1'b1;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                end
              end
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign db_level[i]      = db_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign repeat_pulse[i]  = REPEAT_EN ? repeat_q : 1'b0;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one active-high and one active-low instance
// with short debounce/long/repeat times.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pb = 4'b0000;
  logic [3:0] pb_al = 4'b1111;

  logic [3:0] db, pp, rp, lp, qp;
  logic [3:0] db_al, pp_al, rp_al, lp_al, qp_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_in(pb),
    .db_level(db), .press_pulse(pp), .release_pulse(rp),
    .long_pulse(lp), .repeat_pulse(qp)
  );

  button_conditioner #(
    .N_CH(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .pb_in(pb_al),
    .db_level(db_al), .press_pulse(pp_al), .release_pulse(rp_al),
    .long_pulse(lp_al), .repeat_pulse(qp_al)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pb    = 4'b0000;
    pb_al = 4'b1111;
    repeat (3) step();
    checks++;
    if ({db, pp, rp, lp, qp} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required 00000", {db, pp, rp, lp, qp});
    end
    checks++;
    if ({db_al, pp_al, rp_al, lp_al, qp_al} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state_al: outputs=%h required 00000", {db_al, pp_al, rp_al, lp_al, qp_al});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if ({db, pp, rp, lp, qp, db_al, pp_al, rp_al, lp_al, qp_al} !== 40'h0) begin
        errors++;
        $display("FAIL post_reset_idle edge %0d: dut=%h al=%h required 0",
                 k, {db, pp, rp, lp, qp}, {db_al, pp_al, rp_al, lp_al, qp_al});
      end
    end
  endtask

  task automatic test_clean_press();
    pb[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (db !== ((k >= 5) ? 4'b0001 : 4'b0000) || pp !== ((k == 5) ? 4'b0001 : 4'b0000) ||
          rp !== 4'b0 || lp !== 4'b0 || qp !== 4'b0) begin
        errors++;
        $display("FAIL clean_press edge %0d: db=%b press=%b rel=%b long=%b rep=%b required db=%b press=%b",
                 k, db, pp, rp, lp, qp, (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000);
      end
    end
    pb[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (db !== ((k >= 5) ? 4'b0000 : 4'b0001) || rp !== ((k == 5) ? 4'b0001 : 4'b0000) ||
          pp !== 4'b0 || lp !== 4'b0 || qp !== 4'b0) begin
        errors++;
        $display("FAIL clean_release edge %0d: db=%b press=%b rel=%b long=%b rep=%b", k, db, pp, rp, lp, qp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      pb[1] = ((c % 5) < 3);
      step();
      checks++;
      if (db !== 4'b0 || pp !== 4'b0 || rp !== 4'b0) begin
        errors++;
        $display("FAIL bounce cycle %0d: db=%b press=%b rel=%b required all 0", c, db, pp, rp);
      end
    end
    pb[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (pp !== ((k == 5) ? 4'b0010 : 4'b0000) || db !== ((k >= 5) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_settle edge %0d: db=%b press=%b", k, db, pp);
      end
    end
    pb[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (rp !== ((k == 5) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_release edge %0d: rel=%b", k, rp);
      end
    end
  endtask

  task automatic test_long_repeat();
    int  found;
    logic [3:0] exp_rep;
    found = -1;
    pb[2] = 1'b1;
    for (int n = 0; n < 10 && found < 0; n++) begin
      step();
      if (pp[2]) found = n;
    end
    checks++;
    if (found != 5 || pp !== 4'b0100) begin
      errors++;
      $display("FAIL long_press_latency: press at edge %0d press=%b required edge 5 press=0100", found, pp);
    end
    for (int k = 1; k <= 70; k++) begin
      if (k == 56) pb[2] = 1'b0;
      step();
      exp_rep = (k > 20 && ((k - 20) % 8) == 0 && k < 61) ? 4'b0100 : 4'b0000;
      checks++;
      if (lp !== ((k == 20) ? 4'b0100 : 4'b0000) || qp !== exp_rep ||
          rp !== ((k == 61) ? 4'b0100 : 4'b0000) || pp !== 4'b0 ||
          db !== ((k < 61) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL long_repeat press+%0d: db=%b press=%b rel=%b long=%b rep=%b required rep=%b",
                 k, db, pp, rp, lp, qp, exp_rep);
      end
    end
  endtask

  task automatic test_short_hold();
    int found;
    found = -1;
    pb[3] = 1'b1;
    for (int n = 0; n < 10 && found < 0; n++) begin
      step();
      if (pp[3]) found = n;
    end
    checks++;
    if (found != 5) begin
      errors++;
      $display("FAIL short_press_latency: press at edge %0d required 5", found);
    end
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) pb[3] = 1'b0;
      step();
      checks++;
      if (lp !== 4'b0 || qp !== 4'b0 || pp !== 4'b0 ||
          rp !== ((k == 16) ? 4'b1000 : 4'b0000) || db !== ((k < 16) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL short_hold press+%0d: db=%b press=%b rel=%b long=%b rep=%b", k, db, pp, rp, lp, qp);
      end
    end
  endtask

  task automatic test_active_low();
    for (int k = 0; k < 20; k++) begin
      pb_al[0] = (k < 10) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (pp_al !== ((k == 5) ? 4'b0001 : 4'b0000) || rp_al !== ((k == 15) ? 4'b0001 : 4'b0000) ||
          db_al !== ((k >= 5 && k < 15) ? 4'b0001 : 4'b0000) || lp_al !== 4'b0 || qp_al !== 4'b0) begin
        errors++;
        $display("FAIL active_low edge %0d: db=%b press=%b rel=%b long=%b rep=%b",
                 k, db_al, pp_al, rp_al, lp_al, qp_al);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    pb = 4'b1001;
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (pp !== ((n == 5) ? 4'b1001 : 4'b0000)) begin
        errors++;
        $display("FAIL dual_press edge %0d: press=%b required %b", n, pp, (n == 5) ? 4'b1001 : 4'b0000);
      end
    end
    repeat (15) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({db, pp, rp, lp, qp, db_al, pp_al, rp_al, lp_al, qp_al} !== 40'h0) begin
      errors++;
      $display("FAIL async_reset: dut=%h al=%h required 0", {db, pp, rp, lp, qp}, {db_al, pp_al, rp_al, lp_al, qp_al});
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({db, pp, rp, lp, qp} !== 20'h0) begin
        errors++;
        $display("FAIL reset_held edge %0d: dut=%h required 0", k, {db, pp, rp, lp, qp});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (pp !== ((k == 5) ? 4'b1001 : 4'b0000) || rp !== 4'b0 || lp !== 4'b0 || qp !== 4'b0 ||
          db !== ((k >= 5) ? 4'b1001 : 4'b0000)) begin
        errors++;
        $display("FAIL repress_after_reset edge %0d: db=%b press=%b rel=%b long=%b rep=%b",
                 k, db, pp, rp, lp, qp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_short_hold();
    test_active_low();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
